// File: rtl/adder_seq_ctrl.sv
// WIDTH-bit add/subtract controller that reuses one 4-bit ripple slice over
// WIDTH/4 cycles, least-significant nibble first, with valid/ready handshakes.

module adder_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  logic [4:0] c;

  always_comb begin
    c[0] = cin_i;
    for (int unsigned i = 0; i < 4; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = c[4];
  end
endmodule

module adder_seq_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);
  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned IW  = $clog2(NIB);
  localparam logic [IW-1:0] IDX_LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0] slice_a, slice_b, slice_sum;
  logic       slice_cout;

  assign slice_a = a_q[{idx_q, 2'b00} +: 4];
  assign slice_b = b_q[{idx_q, 2'b00} +: 4];

  adder_4bit u_slice (
    .a_i   (slice_a),
    .b_i   (slice_b),
    .cin_i (carry_q),
    .sum_o (slice_sum),
    .cout_o(slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[{idx_q, 2'b00} +: 4] = slice_sum;
        carry_d = slice_cout;
        if (idx_q == IDX_LAST) begin
          // Partial result is kept apart so out_sum only changes on completion.
          sum_d   = res_d;
          cout_d  = slice_cout;
          ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_sum[3]) ^ slice_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed and randomized checks of adder_seq_ctrl against an integer-arithmetic
// reference model.

module tb_adder_seq_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int passed = 0;
  int total  = 0;

  adder_seq_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: true arithmetic on unsigned and signed interpretations.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] sum, output logic cout, output logic ovf);
    longint ua, ub, full, sa, sb, sres;
    ua   = longint'(a);
    ub   = longint'(b);
    full = s ? (ua + ((1 << W) - 1 - ub) + 1) : (ua + ub);
    sum  = W'(full);
    cout = full[W];
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    sres = s ? (sa - sb) : (sa + sb);
    ovf  = (sres > (2 ** (W - 1)) - 1) || (sres < -(2 ** (W - 1)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, check latency and result, hold DONE for 'hold' cycles
  // with decoy operands offered, then consume.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int hold);
    logic [W-1:0] esum;
    logic         ecout, eovf;
    int n;
    model(a, b, s, esum, ecout, eovf);
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk("in_ready_before_accept", in_ready, 1'b1);
    in_a = a; in_b = b; in_sub = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); in_sub = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("latency", n, W / 4);
    chk("out_sum", out_sum, esum);
    chk("out_cout", out_cout, ecout);
    chk("out_ovf", out_ovf, eovf);
    chk("in_ready_in_done", in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom); in_sub = 1'($urandom);
      tick();
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_sum", out_sum, esum);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_after_consume", {out_valid, in_ready, busy}, 3'b010);
    chk("sum_stable_in_idle", out_sum, esum);
  endtask

  initial begin
    logic [W-1:0] esum, prev_sum;
    logic         ecout, eovf, pr;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_out_sum", out_sum, 16'h0000);
    chk("reset_flags", {out_cout, out_ovf}, 2'b00);
    rst = 1'b0;

    run_op(16'h1234, 16'h4321, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'h0005, 16'h0007, 1'b1, 0);
    run_op(16'h8000, 16'h0001, 1'b1, 0);
    // Backpressure with ignored decoy operands.
    run_op(16'hA5A5, 16'h1111, 1'b0, 10);

    // Back-to-back issue interval with out_ready held high.
    out_ready = 1'b1;
    in_a = 16'h0F0F; in_b = 16'h00F1; in_sub = 1'b0; in_valid = 1'b1;
    tick();
    in_a = 16'h1000; in_b = 16'h2000; in_sub = 1'b1;
    n = 0;
    pr = 1'b0;
    while (n < 20) begin
      pr = in_ready;
      if (out_valid) prev_sum = out_sum;
      tick();
      n++;
      if (pr) break;
    end
    in_valid = 1'b0;
    chk("issue_interval", n, W / 4 + 2);
    model(16'h0F0F, 16'h00F1, 1'b0, esum, ecout, eovf);
    chk("b2b_first_sum", prev_sum, esum);
    model(16'h1000, 16'h2000, 1'b1, esum, ecout, eovf);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("b2b_second_wait", out_valid, 1'b1);
    chk("b2b_second_sum", out_sum, esum);
    chk("b2b_second_cout", out_cout, ecout);
    tick();
    out_ready = 1'b0;

    // Asynchronous reset while RUN is at nibble index 2.
    in_a = 16'h0FFF; in_b = 16'h0001; in_sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("midrun_rst_busy", busy, 1'b0);
    chk("midrun_rst_out_valid", out_valid, 1'b0);
    chk("midrun_rst_in_ready", in_ready, 1'b1);
    chk("midrun_rst_out_sum", out_sum, 16'h0000);
    #1 rst = 1'b0;
    run_op(16'h0001, 16'h0001, 1'b0, 0);

    for (int k = 0; k < 20; k++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    run_op(16'h8000, 16'h8000, 1'b0, 0);
    run_op(16'h0000, 16'h0000, 1'b1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
